// File: rtl/axi_crossbar_addr_arb_if.sv
// rtl/axi_crossbar_addr_arb_if.sv - requester and master-side address handshake bundle for the port arbiter
interface axi_crossbar_addr_arb_if #(
    parameter int          S_COUNT = 4,
    parameter int unsigned M_ISSUE = 32'd4
);
    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CNT_W = $clog2(M_ISSUE + 1);

    logic [S_COUNT-1:0]   s_req_valid;
    logic [S_COUNT*4-1:0] s_req_qos;
    logic [S_COUNT-1:0]   s_req_ready;
    logic [S_COUNT-1:0]   m_grant;
    logic [IDX_W-1:0]     m_grant_encoded;
    logic                 m_axi_avalid;
    logic                 m_axi_aready;
    logic                 m_cpl_valid;
    logic [CNT_W-1:0]     m_issue_count;

    modport slave (
        input  s_req_valid, s_req_qos, m_axi_aready, m_cpl_valid,
        output s_req_ready, m_grant, m_grant_encoded, m_axi_avalid, m_issue_count
    );

    modport master (
        output s_req_valid, s_req_qos, m_axi_aready, m_cpl_valid,
        input  s_req_ready, m_grant, m_grant_encoded, m_axi_avalid, m_issue_count
    );
endinterface

// File: rtl/axi_crossbar_addr_arb.sv
// rtl/axi_crossbar_addr_arb.sv - QoS/round-robin address arbiter with outstanding-transaction cap
module axi_crossbar_addr_arb #(
    parameter int          S_COUNT    = 4,
    parameter int unsigned M_ISSUE    = 32'd4,
    parameter bit          QOS_ENABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_crossbar_addr_arb_if.slave bus
);
    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CNT_W = $clog2(M_ISSUE + 1);
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(M_ISSUE);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(S_COUNT - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q;
    logic [S_COUNT-1:0] grant_q;
    logic [IDX_W-1:0]   grant_enc_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic               avalid_q;
    logic [CNT_W-1:0]   issue_cnt_q;
    logic [CNT_W-1:0]   issue_cnt_d;

    logic [3:0]         max_qos;
    logic [S_COUNT-1:0] cand;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [S_COUNT-1:0] grant_d;
    logic               hs;
    logic               eligible;

    assign hs       = avalid_q & bus.m_axi_aready;
    assign eligible = (|bus.s_req_valid) && ((issue_cnt_q < ISSUE_MAX) || bus.m_cpl_valid);
    assign grant_d  = S_COUNT'(1) << win_idx;

    always_comb begin
        max_qos = '0;
        cand    = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (bus.s_req_valid[i] && (bus.s_req_qos[i*4 +: 4] > max_qos))
                max_qos = bus.s_req_qos[i*4 +: 4];
        end
        for (int i = 0; i < S_COUNT; i++)
            cand[i] = bus.s_req_valid[i] && (!QOS_ENABLE || (bus.s_req_qos[i*4 +: 4] == max_qos));
    end

    // Scan upward from the requester after the last winner so the previous winner is considered last.
    always_comb begin
        rr_idx    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= S_COUNT; k++) begin
            rr_idx = IDX_W'((int'(last_grant_q) + k) % S_COUNT);
            if (!win_found && cand[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    // A handshake and a completion in the same cycle cancel; completions at zero are dropped.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (hs && !bus.m_cpl_valid)
            issue_cnt_d = issue_cnt_q + 1'b1;
        else if (!hs && bus.m_cpl_valid && (issue_cnt_q != '0))
            issue_cnt_d = issue_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_enc_q  <= '0;
            last_grant_q <= LAST_RST;
            avalid_q     <= 1'b0;
            issue_cnt_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            case (state_q)
                IDLE: begin
                    if (eligible && win_found) begin
                        grant_q     <= grant_d;
                        grant_enc_q <= win_idx;
                        avalid_q    <= 1'b1;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hs) begin
                        last_grant_q <= grant_enc_q;
                        avalid_q     <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_req_ready     = hs ? grant_q : '0;
    assign bus.m_grant         = grant_q;
    assign bus.m_grant_encoded = grant_enc_q;
    assign bus.m_axi_avalid    = avalid_q;
    assign bus.m_issue_count   = issue_cnt_q;
endmodule
